// File: rtl/ip_hdr_sched.sv
// ip_hdr_sched: shares one IPv4 header checksum unit between two header requesters.
// Arbitrates req0 (UDP TX) against req1 (ICMP reply). Registers the winner's header fields onto
// the check_sum inputs and latches the resulting checksum. Streams the 20-byte IPv4 header to
// the MAC TX framer under a valid/ready handshake. Also owns the IP identification counter.
//
// Ports:
//   i_clk, i_rst                  clock, synchronous active-high reset
//   i_reqN_valid/proto/src_ip/    requester N header request (N = 0, 1); fields held until
//   dst_ip/len, o_reqN_grant      the one-cycle combinational grant
//   o_ck_*                        registered inputs to the external check_sum unit
//   i_ck_sum                      combinational checksum result from check_sum
//   o_hdr_data/valid/last/src,    header byte stream to the MAC framer
//   i_hdr_ready
//   o_len_err                     one-cycle pulse: an oversize request was dropped
//   o_busy                        high whenever the scheduler is not idle
module ip_hdr_sched #(
  parameter logic [7:0]  TTL     = 8'h40,
  parameter logic [15:0] ID_INIT = 16'h0000,
  parameter bit          RR_EN   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req0_valid,
  input  logic [7:0]  i_req0_proto,
  input  logic [31:0] i_req0_src_ip,
  input  logic [31:0] i_req0_dst_ip,
  input  logic [15:0] i_req0_len,
  output logic        o_req0_grant,
  input  logic        i_req1_valid,
  input  logic [7:0]  i_req1_proto,
  input  logic [31:0] i_req1_src_ip,
  input  logic [31:0] i_req1_dst_ip,
  input  logic [15:0] i_req1_len,
  output logic        o_req1_grant,
  output logic [15:0] o_ck_tot_len,
  output logic [15:0] o_ck_id,
  output logic [7:0]  o_ck_ttl,
  output logic [7:0]  o_ck_protocol,
  output logic [31:0] o_ck_src_ip,
  output logic [31:0] o_ck_dst_ip,
  input  logic [15:0] i_ck_sum,
  output logic [7:0]  o_hdr_data,
  output logic        o_hdr_valid,
  input  logic        i_hdr_ready,
  output logic        o_hdr_last,
  output logic        o_hdr_src,
  output logic        o_len_err,
  output logic        o_busy
);

  typedef enum logic [1:0] {StIdle, StCsum, StSend} state_e;

  localparam logic [4:0]  LastIdx = 5'd19;
  // Largest payload whose total length (payload + 20-byte header) still fits in 16 bits.
  localparam logic [15:0] MaxLen  = 16'hFFEB;

  state_e      r_state;
  state_e      w_state_nxt;
  logic [15:0] r_id;
  logic        r_last_sel;   // requester served most recently (round-robin pointer)
  logic        r_src;
  logic        r_len_err;
  logic [15:0] r_csum;
  logic [4:0]  r_idx;
  logic [15:0] r_ck_tot_len;
  logic [15:0] r_ck_id;
  logic [7:0]  r_ck_ttl;
  logic [7:0]  r_ck_protocol;
  logic [31:0] r_ck_src_ip;
  logic [31:0] r_ck_dst_ip;

  logic        w_any;
  logic        w_sel;
  logic        w_accept;
  logic        w_oversize;
  logic        w_xfer;
  logic [7:0]  w_proto;
  logic [31:0] w_src_ip;
  logic [31:0] w_dst_ip;
  logic [15:0] w_len;
  logic [7:0]  w_byte;

  // Arbitration and field selection
  always_comb begin
    w_any = i_req0_valid | i_req1_valid;
    // With both valid, round-robin picks the one not served last; otherwise req0 wins a tie.
    if (RR_EN && i_req0_valid && i_req1_valid) begin
      w_sel = ~r_last_sel;
    end else begin
      w_sel = ~i_req0_valid;
    end
    w_accept   = (r_state == StIdle) && w_any;
    w_proto    = w_sel ? i_req1_proto  : i_req0_proto;
    w_src_ip   = w_sel ? i_req1_src_ip : i_req0_src_ip;
    w_dst_ip   = w_sel ? i_req1_dst_ip : i_req0_dst_ip;
    w_len      = w_sel ? i_req1_len    : i_req0_len;
    w_oversize = w_len > MaxLen;
    w_xfer     = (r_state == StSend) && i_hdr_ready;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (w_accept && !w_oversize) begin
          w_state_nxt = StCsum;
        end
      end
      StCsum: w_state_nxt = StSend;
      StSend: begin
        if (w_xfer && (r_idx == LastIdx)) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  // Header byte selection
  always_comb begin
    w_byte = 8'h00;
    case (r_idx)
      5'd0:    w_byte = 8'h45;
      5'd2:    w_byte = r_ck_tot_len[15:8];
      5'd3:    w_byte = r_ck_tot_len[7:0];
      5'd4:    w_byte = r_ck_id[15:8];
      5'd5:    w_byte = r_ck_id[7:0];
      5'd8:    w_byte = r_ck_ttl;
      5'd9:    w_byte = r_ck_protocol;
      5'd10:   w_byte = r_csum[15:8];
      5'd11:   w_byte = r_csum[7:0];
      5'd12:   w_byte = r_ck_src_ip[31:24];
      5'd13:   w_byte = r_ck_src_ip[23:16];
      5'd14:   w_byte = r_ck_src_ip[15:8];
      5'd15:   w_byte = r_ck_src_ip[7:0];
      5'd16:   w_byte = r_ck_dst_ip[31:24];
      5'd17:   w_byte = r_ck_dst_ip[23:16];
      5'd18:   w_byte = r_ck_dst_ip[15:8];
      5'd19:   w_byte = r_ck_dst_ip[7:0];
      default: w_byte = 8'h00;  // bytes 1, 6, 7: tos and flags/offset are zero
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= StIdle;
      r_id          <= ID_INIT;
      r_last_sel    <= 1'b1;
      r_src         <= 1'b0;
      r_len_err     <= 1'b0;
      r_csum        <= 16'h0000;
      r_idx         <= 5'd0;
      r_ck_tot_len  <= 16'h0000;
      r_ck_id       <= 16'h0000;
      r_ck_ttl      <= 8'h00;
      r_ck_protocol <= 8'h00;
      r_ck_src_ip   <= 32'h0;
      r_ck_dst_ip   <= 32'h0;
    end else begin
      r_state   <= w_state_nxt;
      r_len_err <= w_accept && w_oversize;
      if (w_accept) begin
        // Oversize requests still load these; the total length simply wraps and is never sent.
        r_ck_tot_len  <= w_len + 16'd20;
        r_ck_id       <= r_id;
        r_ck_ttl      <= TTL;
        r_ck_protocol <= w_proto;
        r_ck_src_ip   <= w_src_ip;
        r_ck_dst_ip   <= w_dst_ip;
        r_src         <= w_sel;
        r_last_sel    <= w_sel;
      end
      if (r_state == StCsum) begin
        r_csum <= i_ck_sum;
        r_idx  <= 5'd0;
      end
      if (w_xfer) begin
        if (r_idx == LastIdx) begin
          r_id <= r_id + 16'd1;
        end else begin
          r_idx <= r_idx + 5'd1;
        end
      end
    end
  end

  assign o_req0_grant  = w_accept && !w_sel;
  assign o_req1_grant  = w_accept && w_sel;
  assign o_ck_tot_len  = r_ck_tot_len;
  assign o_ck_id       = r_ck_id;
  assign o_ck_ttl      = r_ck_ttl;
  assign o_ck_protocol = r_ck_protocol;
  assign o_ck_src_ip   = r_ck_src_ip;
  assign o_ck_dst_ip   = r_ck_dst_ip;
  assign o_hdr_valid   = (r_state == StSend);
  assign o_hdr_data    = (r_state == StSend) ? w_byte : 8'h00;
  assign o_hdr_last    = (r_state == StSend) && (r_idx == LastIdx);
  assign o_hdr_src     = r_src;
  assign o_len_err     = r_len_err;
  assign o_busy        = (r_state != StIdle);

endmodule

// File: tb/tb_ip_hdr_sched.sv
// tb_ip_hdr_sched: directed bench for ip_hdr_sched.
// Three instances share all stimulus: [0] defaults, [1] fixed priority, [2] ID_INIT = FFFF.
// Each instance gets its own behavioural IPv4 checksum model on its ck_* outputs.
module tb_ip_hdr_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        r0v, r1v, hdr_ready;
  logic [7:0]  r0p, r1p;
  logic [31:0] r0s, r0d, r1s, r1d;
  logic [15:0] r0l, r1l;

  logic        g0 [3];
  logic        g1 [3];
  logic [15:0] ck_tl [3];
  logic [15:0] ck_id [3];
  logic [7:0]  ck_ttl [3];
  logic [7:0]  ck_pr [3];
  logic [31:0] ck_s [3];
  logic [31:0] ck_d [3];
  logic [15:0] ck_sum [3];
  logic [7:0]  hd [3];
  logic        hv [3];
  logic        hl [3];
  logic        hs [3];
  logic        le [3];
  logic        bz [3];

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_b [20];

  // One's-complement sum of the header with ver=4, hdr_len=5, tos=0, offset=0, checksum=0.
  function automatic logic [15:0] csum_f(input logic [15:0] tl, input logic [15:0] id,
                                         input logic [7:0] ttl, input logic [7:0] pr,
                                         input logic [31:0] s, input logic [31:0] d);
    logic [31:0] acc;
    acc = 32'h4500 + {16'h0, tl} + {16'h0, id} + {16'h0, ttl, pr} + {16'h0, s[31:16]} +
          {16'h0, s[15:0]} + {16'h0, d[31:16]} + {16'h0, d[15:0]};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    acc = {16'h0, acc[15:0]} + {16'h0, acc[31:16]};
    return ~acc[15:0];
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    ip_hdr_sched #(
      .TTL     (8'h40),
      .ID_INIT ((g == 2) ? 16'hFFFF : 16'h0000),
      .RR_EN   ((g == 1) ? 1'b0 : 1'b1)
    ) u_dut (
      .i_clk         (clk),
      .i_rst         (rst),
      .i_req0_valid  (r0v),
      .i_req0_proto  (r0p),
      .i_req0_src_ip (r0s),
      .i_req0_dst_ip (r0d),
      .i_req0_len    (r0l),
      .o_req0_grant  (g0[g]),
      .i_req1_valid  (r1v),
      .i_req1_proto  (r1p),
      .i_req1_src_ip (r1s),
      .i_req1_dst_ip (r1d),
      .i_req1_len    (r1l),
      .o_req1_grant  (g1[g]),
      .o_ck_tot_len  (ck_tl[g]),
      .o_ck_id       (ck_id[g]),
      .o_ck_ttl      (ck_ttl[g]),
      .o_ck_protocol (ck_pr[g]),
      .o_ck_src_ip   (ck_s[g]),
      .o_ck_dst_ip   (ck_d[g]),
      .i_ck_sum      (ck_sum[g]),
      .o_hdr_data    (hd[g]),
      .o_hdr_valid   (hv[g]),
      .i_hdr_ready   (hdr_ready),
      .o_hdr_last    (hl[g]),
      .o_hdr_src     (hs[g]),
      .o_len_err     (le[g]),
      .o_busy        (bz[g])
    );
    assign ck_sum[g] = csum_f(ck_tl[g], ck_id[g], ck_ttl[g], ck_pr[g], ck_s[g], ck_d[g]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // Raise a request at a negedge, check the same-cycle grant, drop it one cycle later (T+1).
  task automatic issue(input bit which, input logic [7:0] p, input logic [31:0] s,
                       input logic [31:0] d, input logic [15:0] l);
    if (which) begin
      r1p = p; r1s = s; r1d = d; r1l = l; r1v = 1'b1;
    end else begin
      r0p = p; r0s = s; r0d = d; r0l = l; r0v = 1'b1;
    end
    #1;
    chk("grant0", g0[0], {31'b0, !which});
    chk("grant1", g1[0], {31'b0, which});
    @(negedge clk);
    r0v = 1'b0;
    r1v = 1'b0;
  endtask

  task automatic fill_exp(input logic [15:0] tl, input logic [15:0] id, input logic [7:0] pr,
                          input logic [31:0] s, input logic [31:0] d);
    logic [15:0] cs;
    cs = csum_f(tl, id, 8'h40, pr, s, d);
    exp_b[0]  = 8'h45;      exp_b[1]  = 8'h00;      exp_b[2]  = tl[15:8];  exp_b[3]  = tl[7:0];
    exp_b[4]  = id[15:8];   exp_b[5]  = id[7:0];    exp_b[6]  = 8'h00;     exp_b[7]  = 8'h00;
    exp_b[8]  = 8'h40;      exp_b[9]  = pr;         exp_b[10] = cs[15:8];  exp_b[11] = cs[7:0];
    exp_b[12] = s[31:24];   exp_b[13] = s[23:16];   exp_b[14] = s[15:8];   exp_b[15] = s[7:0];
    exp_b[16] = d[31:24];   exp_b[17] = d[23:16];   exp_b[18] = d[15:8];   exp_b[19] = d[7:0];
  endtask

  // Called at T+1; expects the first byte at T+2, then 20 bytes; optional stall at stall_idx.
  task automatic recv(input int k, input logic exp_src, input int stall_idx);
    int n;
    n = 0;
    while (hv[k] !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid_latency", n, 1);
    for (int i = 0; i < 20; i++) begin
      chk($sformatf("byte%0d", i), {24'h0, hd[k]}, {24'h0, exp_b[i]});
      chk($sformatf("last%0d", i), {31'b0, hl[k]}, {31'b0, (i == 19)});
      chk($sformatf("src%0d", i), {31'b0, hs[k]}, {31'b0, exp_src});
      if (i == stall_idx) begin
        hdr_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("stall_data", {24'h0, hd[k]}, {24'h0, exp_b[i]});
          chk("stall_valid", {31'b0, hv[k]}, 32'd1);
          chk("stall_last", {31'b0, hl[k]}, 32'd0);
        end
        hdr_ready = 1'b1;
      end
      @(negedge clk);
    end
    chk("idle_after_hdr", {31'b0, bz[k]}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [159:0] lit1;
    logic [15:0]  cs;
    int ng0, ng1;
    logic seq0 [4];
    logic seq1 [4];

    rst = 1'b1; hdr_ready = 1'b1;
    r0v = 1'b0; r0p = '0; r0s = '0; r0d = '0; r0l = '0;
    r1v = 1'b0; r1p = '0; r1s = '0; r1d = '0; r1l = '0;
    repeat (3) @(negedge clk);

    // Reset values
    chk("rst_hdr_valid", {31'b0, hv[0]}, 32'd0);
    chk("rst_busy", {31'b0, bz[0]}, 32'd0);
    chk("rst_ck_tot_len", {16'h0, ck_tl[0]}, 32'd0);
    chk("rst_ck_id", {16'h0, ck_id[0]}, 32'd0);
    chk("rst_len_err", {31'b0, le[0]}, 32'd0);
    chk("rst_hdr_data", {24'h0, hd[0]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: first header, hand-computed bytes
    issue(1'b0, 8'h11, 32'hC0A80002, 32'hC0A80003, 16'h001E);
    chk("t1_busy_csum", {31'b0, bz[0]}, 32'd1);
    chk("t1_no_valid_csum", {31'b0, hv[0]}, 32'd0);
    chk("t1_ck_tot_len", {16'h0, ck_tl[0]}, 32'h0032);
    chk("t1_ck_ttl", {24'h0, ck_ttl[0]}, 32'h40);
    chk("t1_id_init_ffff", {16'h0, ck_id[2]}, 32'hFFFF);
    lit1 = 160'h4500_0032_0000_0000_4011_F965_C0A8_0002_C0A8_0003;
    for (int i = 0; i < 20; i++) exp_b[i] = lit1[159 - 8 * i -: 8];
    recv(0, 1'b0, -1);

    // 2: second header, id increments; [2] wraps FFFF -> 0000
    issue(1'b0, 8'h11, 32'hC0A80005, 32'hC0A80008, 16'h001E);
    chk("t2_ck_id", {16'h0, ck_id[0]}, 32'h0001);
    chk("t2_id_wrap", {16'h0, ck_id[2]}, 32'h0000);
    fill_exp(16'h0032, 16'h0001, 8'h11, 32'hC0A80005, 32'hC0A80008);
    recv(0, 1'b0, -1);

    // 3: both requesters continuously valid
    do_reset();
    r0p = 8'h11; r0s = 32'hC0A80002; r0d = 32'hC0A80003; r0l = 16'h001E;
    r1p = 8'h01; r1s = 32'h0A000001; r1d = 32'h0A000002; r1l = 16'h0010;
    r0v = 1'b1; r1v = 1'b1;
    ng0 = 0; ng1 = 0;
    for (int c = 0; c < 150 && (ng0 < 4 || ng1 < 4); c++) begin
      #1;
      if ((g0[0] || g1[0]) && ng0 < 4) begin seq0[ng0] = g1[0]; ng0++; end
      if ((g0[1] || g1[1]) && ng1 < 4) begin seq1[ng1] = g1[1]; ng1++; end
      @(negedge clk);
    end
    chk("t3_rr_grant_count", ng0, 4);
    chk("t3_fp_grant_count", ng1, 4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng0) chk($sformatf("t3_rr_grant%0d", i), {31'b0, seq0[i]}, i % 2);
      if (i < ng1) chk($sformatf("t3_fp_grant%0d", i), {31'b0, seq1[i]}, 32'd0);
    end
    r0v = 1'b0; r1v = 1'b0;
    do_reset();

    // 4: back-pressure on the TTL byte
    issue(1'b0, 8'h11, 32'hC0A80002, 32'hC0A80003, 16'h001E);
    for (int i = 0; i < 20; i++) exp_b[i] = lit1[159 - 8 * i -: 8];
    recv(0, 1'b0, 8);

    // 5: oversize request dropped, then the largest legal length
    issue(1'b1, 8'h01, 32'h0A000001, 32'h0A000002, 16'hFFEC);
    chk("t5_len_err", {31'b0, le[0]}, 32'd1);
    chk("t5_no_valid", {31'b0, hv[0]}, 32'd0);
    chk("t5_not_busy", {31'b0, bz[0]}, 32'd0);
    @(negedge clk);
    chk("t5_len_err_pulse", {31'b0, le[0]}, 32'd0);
    chk("t5_still_no_valid", {31'b0, hv[0]}, 32'd0);
    issue(1'b1, 8'h01, 32'h0A000001, 32'h0A000002, 16'hFFEB);
    chk("t5_tot_len_ffff", {16'h0, ck_tl[0]}, 32'hFFFF);
    chk("t5_id_unchanged", {16'h0, ck_id[0]}, 32'h0001);
    fill_exp(16'hFFFF, 16'h0001, 8'h01, 32'h0A000001, 32'h0A000002);
    recv(0, 1'b1, -1);

    // 6: ID_INIT = FFFF wrap, then reset in the middle of a header
    do_reset();
    issue(1'b0, 8'h11, 32'hC0A80002, 32'hC0A80003, 16'h001E);
    chk("t6_id_first", {16'h0, ck_id[2]}, 32'hFFFF);
    fill_exp(16'h0032, 16'hFFFF, 8'h11, 32'hC0A80002, 32'hC0A80003);
    recv(2, 1'b0, -1);
    issue(1'b0, 8'h11, 32'hC0A80002, 32'hC0A80003, 16'h001E);
    chk("t6_id_second", {16'h0, ck_id[2]}, 32'h0000);
    repeat (11) @(negedge clk);
    cs = csum_f(16'h0032, 16'h0000, 8'h40, 8'h11, 32'hC0A80002, 32'hC0A80003);
    chk("t6_at_byte10_valid", {31'b0, hv[2]}, 32'd1);
    chk("t6_at_byte10_data", {24'h0, hd[2]}, {24'h0, cs[15:8]});
    rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_valid", {31'b0, hv[2]}, 32'd0);
    chk("t6_rst_busy", {31'b0, bz[2]}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    issue(1'b0, 8'h11, 32'hC0A80002, 32'hC0A80003, 16'h001E);
    chk("t6_id_back_to_init", {16'h0, ck_id[2]}, 32'hFFFF);
    chk("t6_id_default_inst", {16'h0, ck_id[0]}, 32'h0000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
